am_modulator: RTL and testbench
===============================

Name: am_modulator

Overview:
- Standard-AM transmitter: the other end of the AM demodulator datapath. It generates the test stimulus and loopback signal for the demodulator chain.
- Takes a stream of signed 16-bit message samples and adds a programmable DC carrier level to form the envelope.
- Multiplies the envelope by a sine carrier from a phase-accumulator NCO and streams out signed 16-bit AM samples.
- Valid/ready on both sides; output feeds the demodulator input directly.

Parameters:
- DATA_W, 16, sample width for msg, dc_offset and output (signed, Q1.15).
- PHASE_W, 32, NCO phase accumulator width.
- LUT_ADDR_W, 8, sine LUT address bits; index = phase[PHASE_W-1 -: LUT_ADDR_W].

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- phase_inc  in  PHASE_W  carrier phase step per accepted sample; f_c = phase_inc/2^PHASE_W * f_s.
- dc_offset  in  DATA_W  signed carrier level A added to every message sample.
- msg_data  in  DATA_W  signed message sample.
- msg_valid  in  1  msg_data valid.
- msg_ready  out  1  module accepts msg_data this cycle.
- am_data  out  DATA_W  signed modulated sample.
- am_valid  out  1  am_data valid.
- am_ready  in  1  downstream accepts am_data.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
  - While rst_n=0: am_valid=0, am_data=0, all stage valids=0, phase accumulator=0.
  - msg_ready=1 once reset is released; its value during reset is don't-care.
- Pipeline: 3 stages with a common enable en = !am_valid || am_ready. msg_ready = en (combinational).
  - All stages hold when en=0.
  - Accept occurs on msg_valid && msg_ready.
- S1, on accept:
  - env = sat16(dc_offset + msg_data), with a 17-bit signed sum clamped to [-32768, 32767].
  - lut_idx = phase[31:24].
  - phase <= phase + phase_inc, mod 2^32.
  - The first sample after reset uses phase 0.
  - Phase advances only on accepted samples, never on idle cycles.
- S2: sine = LUT[lut_idx], where LUT[k] = round(32767*sin(2*pi*k/256)), signed 16-bit.
  - Either a full 256-entry table or quarter-wave with symmetry is allowed; the two must be bit-identical.
  - env is carried alongside.
- S3: prod = env*sine (32-bit signed); am_data = sat16((prod + 2^14) >>> 15).
  - Rounding is half-up toward +inf.
  - Saturation is kept even though it is unreachable for legal LUT values.
- Latency: an accepted sample appears on am_data 3 cycles later when am_ready is held high. Throughput is 1 sample/clk.
- Bubbles: when msg_valid=0 with en=1, a bubble propagates. The stage valid bits track it and phase does not advance.
- Backpressure: when am_valid=1 && am_ready=0, am_data and am_valid stay stable, msg_ready=0, no stage advances, and no sample is lost or duplicated.
- Runtime config changes:
  - phase_inc and dc_offset are sampled at S1 on each accept.
  - A change applies to the next accepted sample only; in-flight samples are unaffected.
- Reset mid-stream: async clear, so in-flight samples are discarded and the phase restarts at 0.

Test Plan:
1. Reset: assert rst_n=0 with random inputs -> am_valid=0, am_data=0 immediately; after release msg_ready=1.
2. Quarter-cycle carrier: phase_inc=0x4000_0000, dc_offset=16384, msg_data=0, 4 samples, am_ready=1 -> am_data = 0, 16384, 0, -16383. First output appears 3 cycles after the first accept.
3. Envelope saturation: dc_offset=32000, msg_data=2000, phase_inc=0x4000_0000, second sample (sine=32767) -> am_data=32766. Repeat with dc_offset=-32000, msg=-2000 -> -32767.
4. Backpressure: 20-sample stream, am_ready low for cycles 5-9 -> msg_ready=0 for those cycles, am_data held stable, and the output sequence equals the reference model with no drops or duplicates.
5. Bubbles: msg_valid toggling every other cycle, phase_inc=0x0100_0000 -> LUT indices on accepted samples are 0,1,2,3... with no skips.
6. Mid-stream reset: assert rst_n=0 for 1 cycle during streaming -> pipeline empties, and the next accepted sample uses index 0.

Source files
------------

// File: rtl/am_modulator.sv
// Standard-AM modulator: saturated envelope (carrier level + message) times an NCO sine carrier.
// Three-stage valid/ready pipeline sharing one enable; the phase advances only on accepted samples.
module am_modulator #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned LUT_ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [DATA_W-1:0]  dc_offset,
    input  logic [DATA_W-1:0]  msg_data,
    input  logic               msg_valid,
    output logic               msg_ready,
    output logic [DATA_W-1:0]  am_data,
    output logic               am_valid,
    input  logic               am_ready
);

    localparam logic [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MaxNeg = {1'b1, {(DATA_W-1){1'b0}}};

    logic                  r_v1, r_v2, r_v3;
    logic [PHASE_W-1:0]    r_phase;
    logic [DATA_W-1:0]     r_env1, r_env2, r_sin2, r_am;
    logic [LUT_ADDR_W-1:0] r_idx1;

    logic                  w_en, w_accept;
    logic [DATA_W:0]       w_sum;
    logic [DATA_W-1:0]     w_env, w_qmag, w_sine, w_am;
    logic [LUT_ADDR_W-3:0] w_qidx;
    logic [LUT_ADDR_W-2:0] w_qaddr;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W+1:0]     w_shr;
    logic [2:0]            w_top;
    logic                  w_unused_lsb;

    assign w_en      = !r_v3 || am_ready;
    assign w_accept  = msg_valid && w_en;
    assign msg_ready = w_en;
    assign am_valid  = r_v3;
    assign am_data   = r_am;

    assign w_sum = {dc_offset[DATA_W-1], dc_offset} + {msg_data[DATA_W-1], msg_data};

    always_comb begin
        w_env = w_sum[DATA_W-1:0];
        if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
            w_env = w_sum[DATA_W] ? MaxNeg : MaxPos;
        end
    end

    // Quarter-wave table: odd quadrants mirror the address, the upper half negates the result.
    assign w_qidx  = r_idx1[LUT_ADDR_W-3:0];
    assign w_qaddr = r_idx1[LUT_ADDR_W-2] ? ({1'b1, {(LUT_ADDR_W-2){1'b0}}} - {1'b0, w_qidx})
                                          : {1'b0, w_qidx};

    always_comb begin
        w_qmag = '0;
        case (w_qaddr)
            7'd0:  w_qmag = 16'd0;     7'd1:  w_qmag = 16'd804;   7'd2:  w_qmag = 16'd1608;
            7'd3:  w_qmag = 16'd2410;  7'd4:  w_qmag = 16'd3212;  7'd5:  w_qmag = 16'd4011;
            7'd6:  w_qmag = 16'd4808;  7'd7:  w_qmag = 16'd5602;  7'd8:  w_qmag = 16'd6393;
            7'd9:  w_qmag = 16'd7179;  7'd10: w_qmag = 16'd7962;  7'd11: w_qmag = 16'd8739;
            7'd12: w_qmag = 16'd9512;  7'd13: w_qmag = 16'd10278; 7'd14: w_qmag = 16'd11039;
            7'd15: w_qmag = 16'd11793; 7'd16: w_qmag = 16'd12539; 7'd17: w_qmag = 16'd13279;
            7'd18: w_qmag = 16'd14010; 7'd19: w_qmag = 16'd14732; 7'd20: w_qmag = 16'd15446;
            7'd21: w_qmag = 16'd16151; 7'd22: w_qmag = 16'd16846; 7'd23: w_qmag = 16'd17530;
            7'd24: w_qmag = 16'd18204; 7'd25: w_qmag = 16'd18868; 7'd26: w_qmag = 16'd19519;
            7'd27: w_qmag = 16'd20159; 7'd28: w_qmag = 16'd20787; 7'd29: w_qmag = 16'd21403;
            7'd30: w_qmag = 16'd22005; 7'd31: w_qmag = 16'd22594; 7'd32: w_qmag = 16'd23170;
            7'd33: w_qmag = 16'd23731; 7'd34: w_qmag = 16'd24279; 7'd35: w_qmag = 16'd24811;
            7'd36: w_qmag = 16'd25329; 7'd37: w_qmag = 16'd25832; 7'd38: w_qmag = 16'd26319;
            7'd39: w_qmag = 16'd26790; 7'd40: w_qmag = 16'd27245; 7'd41: w_qmag = 16'd27683;
            7'd42: w_qmag = 16'd28105; 7'd43: w_qmag = 16'd28510; 7'd44: w_qmag = 16'd28898;
            7'd45: w_qmag = 16'd29268; 7'd46: w_qmag = 16'd29621; 7'd47: w_qmag = 16'd29956;
            7'd48: w_qmag = 16'd30273; 7'd49: w_qmag = 16'd30571; 7'd50: w_qmag = 16'd30852;
            7'd51: w_qmag = 16'd31113; 7'd52: w_qmag = 16'd31356; 7'd53: w_qmag = 16'd31580;
            7'd54: w_qmag = 16'd31785; 7'd55: w_qmag = 16'd31971; 7'd56: w_qmag = 16'd32137;
            7'd57: w_qmag = 16'd32285; 7'd58: w_qmag = 16'd32412; 7'd59: w_qmag = 16'd32521;
            7'd60: w_qmag = 16'd32609; 7'd61: w_qmag = 16'd32678; 7'd62: w_qmag = 16'd32728;
            7'd63: w_qmag = 16'd32757; 7'd64: w_qmag = 16'd32767;
            default: w_qmag = '0;
        endcase
    end

    assign w_sine = r_idx1[LUT_ADDR_W-1] ? -w_qmag : w_qmag;

    assign w_prod = $signed({{DATA_W{r_env2[DATA_W-1]}}, r_env2})
                  * $signed({{DATA_W{r_sin2[DATA_W-1]}}, r_sin2});

    // (p + 2^14) >>> 15 == (p >>> 15) + p[14]
    assign w_shr = {w_prod[2*DATA_W-1], w_prod[2*DATA_W-1:DATA_W-1]}
                 + {{(DATA_W+1){1'b0}}, w_prod[DATA_W-2]};
    assign w_top = w_shr[DATA_W+1:DATA_W-1];
    assign w_unused_lsb = ^w_prod[DATA_W-3:0];

    always_comb begin
        w_am = w_shr[DATA_W-1:0];
        if (!((&w_top) || !(|w_top))) begin
            w_am = w_shr[DATA_W+1] ? MaxNeg : MaxPos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_phase <= '0;
            r_env1  <= '0;
            r_idx1  <= '0;
            r_env2  <= '0;
            r_sin2  <= '0;
            r_am    <= '0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_env1  <= w_env;
                r_idx1  <= r_phase[PHASE_W-1 -: LUT_ADDR_W];
                r_phase <= r_phase + phase_inc;
            end
            r_v2   <= r_v1;
            r_env2 <= r_env1;
            r_sin2 <= w_sine;
            r_v3   <= r_v2;
            r_am   <= w_am;
        end
    end

endmodule

// File: tb/tb_am_modulator.sv
// Directed bench for am_modulator: expected samples are queued on accept and popped on output.
module tb_am_modulator;

    logic        clk;
    logic        rst_n;
    logic [31:0] phase_inc;
    logic [15:0] dc_offset;
    logic [15:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic [15:0] am_data;
    logic        am_valid;
    logic        am_ready;

    am_modulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase_inc (phase_inc),
        .dc_offset (dc_offset),
        .msg_data  (msg_data),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .am_data   (am_data),
        .am_valid  (am_valid),
        .am_ready  (am_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_q[$];
    int          fixed_q[$];
    logic [31:0] m_phase = '0;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_out = -1;
    bit          hold_pending = 1'b0;
    logic [15:0] held_data;

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(int dc, int msg, int idx);
        int     env;
        int     s;
        real    x;
        longint p;
        env = dc + msg;
        if (env > 32767) env = 32767;
        if (env < -32768) env = -32768;
        x = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(idx) / 256.0);
        s = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        p = longint'(env) * longint'(s);
        p = (p + 64'sd16384) >>> 15;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    // One clock: drive at negedge, observe #1 later, let the posedge commit.
    task automatic step(input bit v, input int dc, input int msg, input logic [31:0] inc,
                        input bit rdy, input int exp_rdy);
        int e;
        @(negedge clk);
        msg_valid = v;
        dc_offset = 16'(dc);
        msg_data  = 16'(msg);
        phase_inc = inc;
        am_ready  = rdy;
        #1;
        if (exp_rdy >= 0) check("msg_ready", msg_ready, exp_rdy);
        if (hold_pending) begin
            check("stall_valid", am_valid, 1);
            check("stall_data", $signed(am_data), int'($signed(held_data)));
        end
        hold_pending = am_valid && !am_ready;
        held_data    = am_data;
        if (am_valid && am_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", am_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("am_data", $signed(am_data), e);
                if (first_out < 0) first_out = cyc;
            end
        end
        if (msg_valid && msg_ready) begin
            if (fixed_q.size() > 0) exp_q.push_back(fixed_q.pop_front());
            else exp_q.push_back(model(dc, msg, int'(m_phase[31:24])));
            m_phase = m_phase + inc;
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 0, 0, 32'h0, 1'b1, -1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        msg_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_am_valid", am_valid, 0);
        check("rst_am_data", $signed(am_data), 0);
        exp_q.delete();
        fixed_q.delete();
        m_phase      = '0;
        hold_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_msg_ready", msg_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b1;
        msg_valid = 1'b0;
        am_ready  = 1'b1;
        phase_inc = '0;
        dc_offset = '0;
        msg_data  = '0;

        // Reset with random inputs applied
        #2;
        rst_n     = 1'b0;
        msg_valid = 1'b1;
        am_ready  = 1'($urandom_range(0, 1));
        phase_inc = $urandom;
        dc_offset = 16'($urandom);
        msg_data  = 16'($urandom);
        #1;
        check("init_am_valid", am_valid, 0);
        check("init_am_data", $signed(am_data), 0);
        repeat (3) @(negedge clk);
        check("init_hold_am_valid", am_valid, 0);
        msg_valid = 1'b0;
        am_ready  = 1'b1;
        rst_n     = 1'b1;
        #1;
        check("init_msg_ready", msg_ready, 1);

        // Quarter-cycle carrier, fixed expectations and latency
        first_acc = -1;
        first_out = -1;
        fixed_q = '{0, 16384, 0, -16383};
        for (int i = 0; i < 4; i++) step(1'b1, 16384, 0, 32'h4000_0000, 1'b1, 1);
        drain();
        check("latency", first_out - first_acc, 3);

        // Envelope saturation, positive then negative
        do_reset();
        fixed_q = '{0, 32766};
        for (int i = 0; i < 2; i++) step(1'b1, 32000, 2000, 32'h4000_0000, 1'b1, 1);
        drain();
        do_reset();
        fixed_q = '{0, -32767};
        for (int i = 0; i < 2; i++) step(1'b1, -32000, -2000, 32'h4000_0000, 1'b1, 1);
        drain();

        // Backpressure: am_ready low for cycles 5-9 of a 20-sample stream
        for (int i = 0; i < 25; i++) begin
            bit rdy;
            rdy = !(i >= 5 && i <= 9);
            step(i < 20, int'($urandom_range(0, 16000)) - 8000,
                 int'($urandom_range(0, 65535)) - 32768, $urandom, rdy, int'(rdy));
        end
        drain();

        // Bubbles: every other cycle idle, indices must step by one per accept
        do_reset();
        for (int i = 0; i < 16; i++) step(i % 2 == 0, 16384, 0, 32'h0100_0000, 1'b1, 1);
        drain();

        // Mid-stream reset: in-flight samples dropped, phase restarts at 0
        for (int i = 0; i < 6; i++) step(1'b1, 12000, 3000, 32'h0300_0000, 1'b1, 1);
        check("pre_rst_am_valid", am_valid, 1);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 20000, -1000, 32'h0500_0000, 1'b1, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
